// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic lab datapath (adder and serial subtractor).
package arith_pkg;

  localparam int ARITH_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/sub1bitpri.sv
// Combinational 1-bit full subtractor cell: D = A - B - Bin, with borrow out.
module sub1bitpri (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Bout,
  output logic D
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/sub_serial_4bit.sv
// Bit-serial two's-complement subtractor n1 - n2, LSB first, one bit per clock,
// with start/busy/done handshake and held result/borrow/overflow outputs.
module sub_serial_4bit
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] n2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] So,
  output logic             Bo,
  output logic             Ov
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bor_q, bor_d;
  logic             n1m_q, n1m_d;
  logic             n2m_q, n2m_d;
  logic [WIDTH-1:0] so_q, so_d;
  logic             bo_q, bo_d;
  logic             ov_q, ov_d;
  logic             busy_q, done_q;
  logic             bit_d, bit_bout;

  sub1bitpri u_cell (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Bin  (bor_q),
    .Bout (bit_bout),
    .D    (bit_d)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    bor_d   = bor_q;
    n1m_d   = n1m_q;
    n2m_d   = n2m_q;
    so_d    = so_q;
    bo_d    = bo_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = n1;
          b_d     = n2;
          n1m_d   = n1[WIDTH-1];
          n2m_d   = n2[WIDTH-1];
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bor_d = bit_bout;
        res_d = {bit_d, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        // Outputs change only on the final bit so partial results never show.
        if (cnt_q == LAST) begin
          so_d    = {bit_d, res_q[WIDTH-1:1]};
          bo_d    = bit_bout;
          ov_d    = (n1m_q != n2m_q) && (bit_d != n1m_q);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      so_q    <= '0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  // Datapath registers are always loaded on accept before use, so no reset.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    res_q <= res_d;
    bor_q <= bor_d;
    n1m_q <= n1m_d;
    n2m_q <= n2m_d;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign So   = so_q;
  assign Bo   = bo_q;
  assign Ov   = ov_q;

endmodule

// File: tb/tb_sub_serial_4bit.sv
// Directed bench for sub_serial_4bit with a result scoreboard and immediate assertions.
module tb_sub_serial_4bit;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] so;
    logic         bo;
    logic         ov;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] n1;
  logic [W-1:0] n2;
  logic         busy;
  logic         done;
  logic [W-1:0] So;
  logic         Bo;
  logic         Ov;

  int checks;
  int errors;
  exp_t sb[$];

  sub_serial_4bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .n1    (n1),
    .n2    (n2),
    .busy  (busy),
    .done  (done),
    .So    (So),
    .Bo    (Bo),
    .Ov    (Ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   ia, ib, diff;
    ia   = int'(a);
    ib   = int'(b);
    diff = (ia - ib) & ((1 << W) - 1);
    e.so = diff[W-1:0];
    e.bo = (ia < ib);
    ia   = (a[W-1]) ? ia - (1 << W) : ia;
    ib   = (b[W-1]) ? ib - (1 << W) : ib;
    e.ov = ((ia - ib) > ((1 << (W-1)) - 1)) || ((ia - ib) < -(1 << (W-1)));
    return e;
  endfunction

  task automatic wait_done(input string tag, input int already);
    int   n;
    exp_t e;
    n = already;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_lat"}, n, W);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_So"}, So, e.so);
      chk({tag, "_Bo"}, Bo, e.bo);
      chk({tag, "_Ov"}, Ov, e.ov);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    n1    = a;
    n2    = b;
    start = 1'b1;
    sb.push_back(model(a, b));
    step();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    wait_done(tag, 0);
  endtask

  initial begin
    logic [W-1:0] hold_so;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    n1     = '0;
    n2     = '0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_So", So, '0);
    chk("rst_Bo", Bo, 1'b0);
    chk("rst_Ov", Ov, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();

    run_op("op7m3", 4'h7, 4'h3);
    step();
    chk("done_pulse", done, 1'b0);
    run_op("op3m7", 4'h3, 4'h7);
    run_op("op7mF", 4'h7, 4'hF);
    hold_so = So;
    step();
    step();
    chk("hold_So", So, hold_so);
    run_op("op8m1", 4'h8, 4'h1);
    run_op("op0m0", 4'h0, 4'h0);
    run_op("op0mF", 4'h0, 4'hF);
    run_op("opFm0", 4'hF, 4'h0);
    run_op("op8m8", 4'h8, 4'h8);
    for (int i = 0; i < 3; i++) begin
      run_op("oprnd", W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    end

    // Held start across RUN; operands change mid-run.
    step();
    n1    = 4'h5;
    n2    = 4'h5;
    start = 1'b1;
    sb.push_back(model(4'h5, 4'h5));
    step();
    step();
    step();
    chk("b2b_run_busy", busy, 1'b1);
    chk("b2b_run_done", done, 1'b0);
    n1 = 4'h9;
    n2 = 4'h2;
    sb.push_back(model(4'h9, 4'h2));
    wait_done("b2b_first", 2);
    step();
    start = 1'b0;
    chk("b2b_second_busy", busy, 1'b1);
    wait_done("b2b_second", 0);

    // Reset during RUN discards the operation.
    step();
    n1    = 4'hA;
    n2    = 4'h3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_So", So, '0);
    chk("mid_rst_Bo", Bo, 1'b0);
    chk("mid_rst_Ov", Ov, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", busy, 1'b0);
    run_op("opAm3", 4'hA, 4'h3);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
